// File: rtl/load_store_unit.sv
// Load/store engine: takes one execute-stage memory request, runs it over a
// valid/ready data bus and returns the extended load result on the writeback port.
//
// state  | meaning
// IDLE   | ready for a new request
// REQ    | mem_valid high, waiting for mem_ready
// WAIT   | load address accepted, waiting for mem_rvalid
// DONE   | one-cycle completion (done, err, writeback)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,

    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES) - 16'd1;

    logic [1:0]  state_q, state_d;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;

    logic        accept;
    logic        req_fault;
    logic        to_hit;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

    assign accept = (state_q == S_IDLE) && req_valid_i;
    assign to_hit = TO_EN && (cnt_q == TO_LAST);

    // Illegal width encodings and natural-alignment violations fault before any bus traffic.
    always_comb begin
        req_fault = 1'b0;
        case (req_funct3_i)
            3'b000:         req_fault = 1'b0;
            3'b001:         req_fault = req_addr_i[0];
            3'b010:         req_fault = (req_addr_i[1:0] != 2'b00);
            3'b100:         req_fault = req_wen_i;
            3'b101:         req_fault = req_wen_i || req_addr_i[0];
            default:        req_fault = 1'b1;
        endcase
    end

    always_comb begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << addr_q[1:0];
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata_i[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = mem_rdata_i[7:0];
            2'd1: ld_byte = mem_rdata_i[15:8];
            2'd2: ld_byte = mem_rdata_i[23:16];
            2'd3: ld_byte = mem_rdata_i[31:24];
            default: ld_byte = mem_rdata_i[7:0];
        endcase
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 16'd0;
                    err_d   = req_fault;
                    data_d  = 32'd0;
                    state_d = req_fault ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_ready_i) begin
                    if (wen_q) begin
                        state_d = S_DONE;
                    end else if (mem_rvalid_i) begin
                        data_d  = ld_result;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid_i) begin
                    data_d  = ld_result;
                    state_d = S_DONE;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            data_q   <= 32'd0;
            cnt_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wen_q    <= req_wen_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                rd_q     <= req_rd_i;
            end
        end
    end

    // Bus and writeback outputs decode only registered state, never req_* directly.
    assign req_ready_o = (state_q == S_IDLE);
    assign mem_valid_o = (state_q == S_REQ);
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wen_o   = mem_valid_o && wen_q;
    assign mem_wmask_o = (mem_valid_o && wen_q) ? lane_mask : 4'd0;
    assign mem_wdata_o = lane_wdata;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = done_o && err_q;
    assign wb_valid_o  = done_o && !err_q && !wen_q && (rd_q != 5'd0);
    assign wb_rd_o     = wb_valid_o ? rd_q : 5'd0;
    assign wb_data_o   = wb_valid_o ? data_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written multi-cycle
// sequences (timeout, reset abort) and randomized traffic against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        d0_req_ready, d0_mem_valid, d0_mem_wen, d0_wb_valid, d0_done, d0_err;
    logic [31:0] d0_mem_addr, d0_mem_wdata, d0_wb_data;
    logic [3:0]  d0_mem_wmask;
    logic [4:0]  d0_wb_rd;
    logic        d4_req_ready, d4_mem_valid, d4_mem_wen, d4_wb_valid, d4_done, d4_err;
    logic [31:0] d4_mem_addr, d4_mem_wdata, d4_wb_data;
    logic [3:0]  d4_mem_wmask;
    logic [4:0]  d4_wb_rd;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_id = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(d0_req_ready), .req_wen_i(req_wen),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .mem_valid_o(d0_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(d0_mem_addr),
        .mem_wen_o(d0_mem_wen), .mem_wmask_o(d0_mem_wmask), .mem_wdata_o(d0_mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .wb_valid_o(d0_wb_valid), .wb_rd_o(d0_wb_rd), .wb_data_o(d0_wb_data),
        .done_o(d0_done), .err_o(d0_err)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(d4_req_ready), .req_wen_i(req_wen),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .mem_valid_o(d4_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(d4_mem_addr),
        .mem_wen_o(d4_mem_wen), .mem_wmask_o(d4_mem_wmask), .mem_wdata_o(d4_mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .wb_valid_o(d4_wb_valid), .wb_rd_o(d4_wb_rd), .wb_data_o(d4_wb_data),
        .done_o(d4_done), .err_o(d4_err)
    );

    typedef struct {
        bit        wen;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit [4:0]  rd;
        int        rdly;
        int        vdly;
        bit        e_err;
        bit        e_wbv;
        bit [31:0] e_data;
        bit [3:0]  e_mask;
        bit [31:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(bit wen, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                                bit [31:0] rdata, bit [4:0] rd, int rdly, int vdly,
                                bit e_err, bit e_wbv, bit [31:0] e_data, bit [3:0] e_mask,
                                bit [31:0] e_wdata);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
        v.rdly = rdly; v.vdly = vdly; v.e_err = e_err; v.e_wbv = e_wbv; v.e_data = e_data;
        v.e_mask = e_mask; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference model: access size from funct3, natural alignment, shift-and-mask extraction.
    function automatic void model(inout vec_t v);
        int             size;
        int             o;
        bit             legal;
        longint unsigned w;
        longint unsigned lim;
        legal = v.wen ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << v.f3[1:0];
        o     = int'(v.addr % 4);
        v.e_err = !legal || ((v.addr % size) != 0);
        v.e_wbv = !v.e_err && !v.wen && (v.rd != 0);
        v.e_mask = (v.wen && !v.e_err) ? 4'(((1 << size) - 1) << o) : 4'd0;
        if (size == 1)      v.e_wdata = (v.wdata % 256) * 32'h0101_0101;
        else if (size == 2) v.e_wdata = (v.wdata % 65536) * 32'h0001_0001;
        else                v.e_wdata = v.wdata;
        w = longint'(v.rdata) >> (8 * o);
        if (size < 4) begin
            lim = 64'd1 << (8 * size);
            w = w % lim;
            if (!v.f3[2] && w >= lim / 2) w = w + 64'h1_0000_0000 - lim;
        end
        v.e_data = w[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (txn %0d): got %h expected %h", nm, cur_id, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic rr, input logic mv, input logic mw,
                            input logic [3:0] mm, input logic [31:0] ma, input logic [31:0] mwd,
                            input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                            input logic dn, input logic er);
        chk({tag, ".req_ready"}, 32'(rr), 32'd1);
        chk({tag, ".mem_valid"}, 32'(mv), 32'd0);
        chk({tag, ".mem_wen"},   32'(mw), 32'd0);
        chk({tag, ".mem_wmask"}, 32'(mm), 32'd0);
        chk({tag, ".mem_addr"},  ma, 32'd0);
        chk({tag, ".mem_wdata"}, mwd, 32'd0);
        chk({tag, ".wb_valid"},  32'(wv), 32'd0);
        chk({tag, ".wb_rd"},     32'(wr), 32'd0);
        chk({tag, ".wb_data"},   wd, 32'd0);
        chk({tag, ".done"},      32'(dn), 32'd0);
        chk({tag, ".err"},       32'(er), 32'd0);
    endtask

    task automatic do_reset();
        req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        req_valid  = 1'b1;
        req_wen    = v.wen;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        step();
        req_valid  = 1'b0;
        req_wen    = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
    endtask

    // One transaction on u_dut with a cooperative bus; checks bus stability, latency and result.
    task automatic run_txn(input vec_t v, input bit noise);
        int  cyc, mvc, reqn, wcnt, exp_lat;
        bit  got, wph;
        chk("idle.req_ready", 32'(d0_req_ready), 32'd1);
        issue(v);
        cyc = 1; mvc = 0; reqn = 0; wcnt = 0; got = 0; wph = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (d0_done) begin
                got = 1;
            end else begin
                if (d0_mem_valid) begin
                    mvc++;
                    chk("req.mem_addr", d0_mem_addr, v.addr & 32'hFFFF_FFFC);
                    chk("req.mem_wen", 32'(d0_mem_wen), 32'(v.wen));
                    chk("req.mem_wmask", 32'(d0_mem_wmask), 32'(v.e_mask));
                    if (v.wen) chk("req.mem_wdata", d0_mem_wdata, v.e_wdata);
                    if (reqn == v.rdly) begin
                        mem_ready = 1'b1;
                        wph = 1;
                        if (!v.wen && v.vdly == 0) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = v.rdata;
                        end
                    end else if (noise) begin
                        mem_rvalid = 1'b1;
                    end
                    reqn++;
                end else if (wph) begin
                    wcnt++;
                    if (wcnt == v.vdly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                    end
                end
                step();
                cyc++;
            end
        end
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        chk("done.seen", 32'(got), 32'd1);
        if (got) begin
            exp_lat = v.e_err ? 1 : (2 + v.rdly + (v.wen ? 0 : v.vdly));
            chk("done.latency", 32'(cyc), 32'(exp_lat));
            chk("done.mem_valid_cycles", 32'(mvc), v.e_err ? 32'd0 : 32'(v.rdly + 1));
            chk("done.err", 32'(d0_err), 32'(v.e_err));
            chk("done.mem_valid", 32'(d0_mem_valid), 32'd0);
            chk("done.wb_valid", 32'(d0_wb_valid), 32'(v.e_wbv));
            if (v.e_wbv) begin
                chk("done.wb_rd", 32'(d0_wb_rd), 32'(v.rd));
                chk("done.wb_data", d0_wb_data, v.e_data);
            end
            step();
            chk("after.done", 32'(d0_done), 32'd0);
            chk("after.req_ready", 32'(d0_req_ready), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   cyc, mvc;
        bit   got;
        bit [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        tbl.push_back(mk(0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 5'd5, 0, 0, 0, 1, 32'hDEAD_BEEF, 4'h0, 32'h0));
        tbl.push_back(mk(0, 3'd0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 5'd7, 1, 2, 0, 1, 32'hFFFF_FF80, 4'h0, 32'h0));
        tbl.push_back(mk(0, 3'd4, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 5'd7, 0, 1, 0, 1, 32'h0000_0080, 4'h0, 32'h0));
        tbl.push_back(mk(1, 3'd1, 32'h0010_0002, 32'h1234_ABCD, 32'h0, 5'd0, 3, 0, 0, 0, 32'h0, 4'b1100, 32'hABCD_ABCD));
        tbl.push_back(mk(0, 3'd1, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 3'd3, 32'h0000_0000, 32'h0, 32'h0, 5'd4, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0));
        tbl.push_back(mk(1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 5'd0, 2, 0, 0, 0, 32'h0, 4'b1000, 32'hA5A5_A5A5));
        tbl.push_back(mk(0, 3'd5, 32'h0000_0402, 32'h0, 32'h8001_FFFF, 5'd9, 0, 3, 0, 1, 32'h0000_8001, 4'h0, 32'h0));
        tbl.push_back(mk(0, 3'd1, 32'h0000_0400, 32'h0, 32'h1234_F00D, 5'd10, 2, 0, 0, 1, 32'hFFFF_F00D, 4'h0, 32'h0));
        tbl.push_back(mk(1, 3'd2, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 5'd0, 1, 0, 0, 0, 32'h0, 4'hF, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 3'd4, 32'h0000_0000, 32'h0, 32'h0, 5'd0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 5'd3, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0));
        tbl.push_back(mk(0, 3'd0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 5'd2, 0, 0, 0, 1, 32'h0000_007F, 4'h0, 32'h0));
        tbl.push_back(mk(1, 3'd1, 32'h0000_0003, 32'h0, 32'h0, 5'd0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0));

        req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        do_reset();
        chk_idle("reset0", d0_req_ready, d0_mem_valid, d0_mem_wen, d0_mem_wmask, d0_mem_addr,
                 d0_mem_wdata, d0_wb_valid, d0_wb_rd, d0_wb_data, d0_done, d0_err);
        chk_idle("reset4", d4_req_ready, d4_mem_valid, d4_mem_wen, d4_mem_wmask, d4_mem_addr,
                 d4_mem_wdata, d4_wb_valid, d4_wb_rd, d4_wb_data, d4_done, d4_err);

        foreach (tbl[i]) begin
            cur_id = i;
            run_txn(tbl[i], 1'b0);
        end

        // Timeout: load address accepted, read data never returns.
        cur_id = 100;
        do_reset();
        v = mk(0, 3'd2, 32'h8000_0010, 32'h0, 32'h0, 5'd5, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        issue(v);
        cyc = 1; mvc = 0; got = 0;
        mem_ready = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (d4_done) begin
                got = 1;
            end else begin
                if (d4_mem_valid) mvc++;
                step();
                cyc++;
            end
        end
        mem_ready = 1'b0;
        chk("to.done_seen", 32'(got), 32'd1);
        chk("to.latency", 32'(cyc), 32'd5);
        chk("to.err", 32'(d4_err), 32'd1);
        chk("to.wb_valid", 32'(d4_wb_valid), 32'd0);
        chk("to.mem_valid_cycles", 32'(mvc), 32'd1);
        step();
        chk("to.idle_ready", 32'(d4_req_ready), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        chk("to.late_rvalid_wb", 32'(d4_wb_valid), 32'd0);
        chk("to.late_rvalid_done", 32'(d4_done), 32'd0);

        // Reset while waiting for read data aborts the load.
        cur_id = 200;
        do_reset();
        v = mk(0, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 5'd3, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        issue(v);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("abort.in_wait_mem_valid", 32'(d0_mem_valid), 32'd0);
        chk("abort.in_wait_done", 32'(d0_done), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("abort", d0_req_ready, d0_mem_valid, d0_mem_wen, d0_mem_wmask, d0_mem_addr,
                 d0_mem_wdata, d0_wb_valid, d0_wb_rd, d0_wb_data, d0_done, d0_err);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        chk("abort.late_rvalid_wb", 32'(d0_wb_valid), 32'd0);
        chk("abort.late_rvalid_done", 32'(d0_done), 32'd0);
        run_txn(mk(0, 3'd2, 32'h0000_0080, 32'h0, 32'h5555_AAAA, 5'd0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0), 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            cur_id = 1000 + n;
            v.wen = 1'($urandom);
            if ($urandom_range(0, 7) == 0) v.f3 = 3'($urandom);
            else if (v.wen)                v.f3 = 3'($urandom_range(0, 2));
            else                           v.f3 = ld_f3[$urandom_range(0, 4)];
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.f3[1:0]) - 32'd1);
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.rd    = 5'($urandom);
            v.rdly  = $urandom_range(0, 3);
            v.vdly  = $urandom_range(0, 3);
            model(v);
            run_txn(v, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access engine for the single-cycle-derived RV32I core.
- Accepts one load/store request from execute (ALU-computed address, rs2 data, rd, funct3).
- Drives a valid/ready data-memory bus and returns aligned, sign/zero-extended load data on a writeback port feeding the register file's memory-data source.
- Stores complete silently. Misaligned accesses, illegal funct3 encodings and bus timeouts are flagged.

Parameters:
TIMEOUT_CYCLES, 0, max cycles spent in REQ+WAIT before abort; 0 disables the timeout; 16-bit counter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_wen  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign encoding
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
mem_valid  out  1  bus request
mem_ready  in  1  bus accepts request
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wen  out  1  write request
mem_wmask  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register index
wb_data  out  32  extended load result
done  out  1  one-cycle completion pulse, every request
err  out  1  qualifies done: request faulted

Behaviour:
- Reset: state IDLE; req_ready=1; mem_valid, mem_wen, wb_valid, done, err=0; mem_addr, mem_wmask, mem_wdata, wb_rd, wb_data=0; timeout counter=0. Reset in any state aborts the transaction. mem_rvalid arriving after an abort is ignored.
- Accept: req_valid&&req_ready in IDLE latches all req_* fields.
- Legal loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Legal stores: funct3 000 sb, 001 sh, 010 sw.
- Fault conditions: any other funct3 (including stores with 1xx), halfword with addr[0]=1, or word with addr[1:0]!=0.
- Fault path: go directly to DONE with err=1. No mem_valid is issued.
- FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE:
  - REQ: mem_valid=1. mem_addr/mem_wen/mem_wmask/mem_wdata are held stable until mem_ready.
    - Store: on mem_ready go to DONE.
    - Load: on mem_ready go to WAIT. If mem_ready&&mem_rvalid in the same cycle, capture data and go straight to DONE.
  - WAIT: mem_valid=0. On mem_rvalid, capture mem_rdata and go to DONE. mem_rvalid in IDLE/REQ-without-ready/DONE is ignored.
  - DONE: one cycle. done=1, err as set. For a non-faulted load with rd!=0: wb_valid=1, wb_rd=rd, wb_data=result. wb_valid=0 for stores, faults and rd==0. req_ready=0.
- Minimum latency: accept at cycle 0, done at cycle 2 with immediate ready+rvalid. Next accept at cycle 3.
- Store lanes, with o=addr[1:0]:
  - sb: mask=4'b0001<<o, wdata={4{b[7:0]}}
  - sh: mask=4'b0011<<o, wdata={2{h[15:0]}}
  - sw: mask=4'b1111, wdata=wdata
  - mem_wmask=0 for loads.
- Load extraction: byte=mem_rdata[8*o+:8], half=mem_rdata[16*o[1]+:16]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
- Timeout (TIMEOUT_CYCLES>0): counter clears on accept and increments each cycle in REQ or WAIT. When counter==TIMEOUT_CYCLES-1 and the event awaited in the current state does not occur that cycle, go to DONE with err=1 and wb_valid=0. mem_valid drops.
- Outputs are registered from state and latched fields; no combinational path from req_* to mem_*.

Test Plan:
- lw addr 0x80000010, mem_ready and mem_rvalid same cycle, rdata 0xDEADBEEF, rd=5 -> DONE at cycle 2: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF, err=0.
- lb addr 0x80000003, rdata 0x80AABBCC, then lbu same -> wb_data 0xFFFFFF80 then 0x00000080.
- sh addr 0x100002 wdata 0x1234ABCD, mem_ready held low 3 cycles -> mem_valid, mem_addr 0x100000, wmask 4'b1100, wdata 0xABCDABCD all stable 4 cycles; done=1, wb_valid=0.
- lh addr 0x101, then funct3=011 load -> each gives done=1, err=1 one cycle after accept, mem_valid never asserted.
- TIMEOUT_CYCLES=4, lw with mem_ready=1 and rvalid never -> done=1, err=1 in cycle 5; late rvalid in IDLE causes no wb_valid.
- rst asserted in WAIT -> next cycle IDLE, req_ready=1, all other outputs 0; following lw with rd=0 gives done=1, wb_valid=0.
